// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding and
// byte/nibble geometry of the load stream.
package boot_pkg;

  typedef enum logic [3:0] {
    IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DAT_LO,
    S_DAT_HI,
    S_WRITE,
    S_START,
    S_DONE,
    S_ERR
  } boot_state_t;

  localparam int LEN_NIBBLE_MSB = 3;
  localparam int BYTE_W         = 8;

endpackage

// File: rtl/boot_loader_byte_pair_assembler.sv
// Joins a latched low byte with the following byte's low nibble into one
// 12-bit word; shared by the length header and every payload word.
module byte_pair_assembler
  import boot_pkg::*;
#(
  parameter int reg_width = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lo_en,
  input  logic                 hi_en,
  input  logic [BYTE_W-1:0]    byte_in,
  output logic [reg_width-1:0] word,
  output logic                 word_valid
);

  logic [BYTE_W-1:0] lo_q;
  logic              unused_hi_nibble;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) lo_q <= '0;
    else if (lo_en) lo_q <= byte_in;
  end

  // The word is formed on the accepting cycle so the FSM can branch on it
  // without an extra cycle; the top registers whatever it keeps.
  assign word       = {byte_in[LEN_NIBBLE_MSB:0], lo_q};
  assign word_valid = hi_en;

  assign unused_hi_nibble = ^byte_in[BYTE_W-1:LEN_NIBBLE_MSB+1];

endmodule

// File: rtl/boot_loader.sv
// Byte-stream program loader: frames a length header plus 12-bit words, writes
// them to instruction memory from address 0, then releases the core.
module boot_loader
  import boot_pkg::*;
#(
  parameter int reg_width = 12,
  parameter int Im_width  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [Im_width-1:0]  im_addr,
  output logic [reg_width-1:0] im_data,
  output logic                 im_wren,
  output logic                 cpu_reset,
  output logic                 start,
  output logic                 busy,
  output logic                 error
);

  localparam logic [reg_width-1:0] CAPACITY = reg_width'(2 ** Im_width);

  boot_state_t          state;
  logic [Im_width:0]    cnt;
  logic [Im_width:0]    cnt_next;
  logic [reg_width-1:0] len_q;
  logic [reg_width-1:0] word;
  logic                 word_valid;
  logic                 accept;
  logic                 lo_en;
  logic                 hi_en;

  assign accept   = rx_valid & rx_ready;
  assign lo_en    = accept & (state == S_LEN_LO || state == S_DAT_LO);
  assign hi_en    = accept & (state == S_LEN_HI || state == S_DAT_HI);
  assign cnt_next = cnt + (Im_width + 1)'(1);

  byte_pair_assembler #(
    .reg_width(reg_width)
  ) u_assembler (
    .clk       (clk),
    .reset     (reset),
    .lo_en     (lo_en),
    .hi_en     (hi_en),
    .byte_in   (rx_data),
    .word      (word),
    .word_valid(word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      im_addr <= '0;
      im_data <= '0;
    end else begin
      case (state)
        IDLE:     if (load_en) state <= S_LEN_LO;
        S_LEN_LO: if (accept) state <= S_LEN_HI;
        S_LEN_HI: begin
          if (word_valid) begin
            len_q <= word;
            if (word == '0) begin
              state <= S_START;
            end else if (word > CAPACITY) begin
              state <= S_ERR;
            end else begin
              cnt   <= '0;
              state <= S_DAT_LO;
            end
          end
        end
        S_DAT_LO: if (accept) state <= S_DAT_HI;
        S_DAT_HI: begin
          if (word_valid) begin
            im_data <= word;
            im_addr <= cnt[Im_width-1:0];
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Counter is one bit wider than the address so a full-capacity
          // load ends on a count match instead of wrapping to zero.
          cnt <= cnt_next;
          if (reg_width'(cnt_next) == len_q) state <= S_START;
          else state <= S_DAT_LO;
        end
        S_START: state <= S_DONE;
        S_DONE:  if (!load_en) state <= IDLE;
        S_ERR:   state <= S_ERR;
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DAT_LO) || (state == S_DAT_HI);
  assign busy      = rx_ready || (state == S_WRITE);
  assign im_wren   = (state == S_WRITE);
  assign start     = (state == S_START);
  assign cpu_reset = !((state == S_START) || (state == S_DONE));
  assign error     = (state == S_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: framed byte streams with random payloads
// and valid gaps, compared against a stream-level model of writes and start.
module tb_boot_loader;

  localparam int RW  = 12;
  localparam int IMW = 8;

  typedef logic [7:0] byte_q_t[$];

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load_en = 1'b0;
  logic           rx_valid = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_ready;
  logic [IMW-1:0] im_addr;
  logic [RW-1:0]  im_data;
  logic           im_wren;
  logic           cpu_reset;
  logic           start;
  logic           busy;
  logic           error;

  boot_loader #(.reg_width(RW), .Im_width(IMW)) dut (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .im_addr  (im_addr),
    .im_data  (im_data),
    .im_wren  (im_wren),
    .cpu_reset(cpu_reset),
    .start    (start),
    .busy     (busy),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tog = 1'b0;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int acc_q[$];
  int start_cnt = 0;
  int start_cyc = -1;
  int start_rst_bad = 0;
  int wren_double = 0;
  bit prev_wren = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: one sample per cycle, away from the active edge.
  always @(negedge clk) begin
    if (im_wren === 1'b1) begin
      wr_addr.push_back(int'(im_addr));
      wr_data.push_back(int'(im_data));
      wr_cyc.push_back(cyc);
      if (prev_wren) wren_double++;
    end
    prev_wren = (im_wren === 1'b1);
    if (start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
      if (cpu_reset !== 1'b0) start_rst_bad++;
    end
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    acc_q.delete();
    start_cnt     = 0;
    start_cyc     = -1;
    start_rst_bad = 0;
    wren_double   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    load_en  = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    clear_mon();
  endtask

  // mode 0: valid held high, 1: valid toggles every cycle, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode, output bit ok);
    bit vld;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (mode == 1) begin
        tog = ~tog;
        vld = tog;
      end else if (mode == 2) begin
        vld = ($urandom_range(0, 2) != 0);
      end else begin
        vld = 1'b1;
      end
      rx_valid = vld;
      rx_data  = vld ? b : 8'($urandom);
      if (vld && rx_ready === 1'b1) begin
        ok = 1'b1;
        acc_q.push_back(cyc);
      end
    end
  endtask

  // Drives one complete valid load and checks it against the stream model.
  task automatic test_load(input string name, input byte_q_t s, input int mode);
    int len;
    int exp_start;
    int exp_data;
    int n;
    bit ok;
    len = int'(s[1] & 8'h0F) * 256 + int'(s[0]);
    @(negedge clk);
    load_en = 1'b1;
    #1;
    clear_mon();
    foreach (s[i]) begin
      send_byte(s[i], mode, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL %s accept byte %0d: accepted 0, required 1", name, i);
        rx_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    for (int t = 0; t < 40 && start_cnt == 0; t++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (cpu_reset !== 1'b0) begin
        errors++;
        $display("FAIL %s cpu_reset after start: got %b, required 0", name, cpu_reset);
      end
    end

    checks++;
    if (wr_addr.size() != len) begin
      errors++;
      $display("FAIL %s write count: got %0d, required %0d", name, wr_addr.size(), len);
    end
    n = (wr_addr.size() < len) ? wr_addr.size() : len;
    for (int i = 0; i < n; i++) begin
      exp_data = int'(s[3+2*i] & 8'h0F) * 256 + int'(s[2+2*i]);
      checks++;
      if (wr_addr[i] != i || wr_data[i] != exp_data) begin
        errors++;
        $display("FAIL %s write %0d: got addr %0d data 0x%03h, required addr %0d data 0x%03h",
                 name, i, wr_addr[i], wr_data[i], i, exp_data);
      end
      checks++;
      if (wr_cyc[i] != acc_q[3+2*i] + 1) begin
        errors++;
        $display("FAIL %s write %0d cycle: got %0d, required %0d", name, i, wr_cyc[i],
                 acc_q[3+2*i] + 1);
      end
    end

    exp_start = (len == 0) ? acc_q[1] + 1 : acc_q[acc_q.size()-1] + 2;
    checks++;
    if (start_cnt != 1) begin
      errors++;
      $display("FAIL %s start pulses: got %0d, required 1", name, start_cnt);
    end
    checks++;
    if (start_cyc != exp_start) begin
      errors++;
      $display("FAIL %s start cycle: got %0d, required %0d", name, start_cyc, exp_start);
    end
    checks++;
    if (start_rst_bad != 0) begin
      errors++;
      $display("FAIL %s cpu_reset during start: got %0d bad cycles, required 0", name,
               start_rst_bad);
    end
    checks++;
    if (wren_double != 0) begin
      errors++;
      $display("FAIL %s im_wren width: got %0d multi-cycle strobes, required 0", name,
               wren_double);
    end
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done state: got busy %b rx_ready %b, required 0 0", name, busy, rx_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rx_ready, im_addr, im_data, im_wren} !== '0) begin
      errors++;
      $display("FAIL reset datapath: got rx_ready %b addr %0h data %0h wren %b, required all 0",
               rx_ready, im_addr, im_data, im_wren);
    end
    checks++;
    if ({cpu_reset, start, busy, error} !== 4'b1000) begin
      errors++;
      $display("FAIL reset control: got cpu_reset/start/busy/error %b%b%b%b, required 1000",
               cpu_reset, start, busy, error);
    end
  endtask

  task automatic test_basic();
    do_reset();
    test_load("basic", '{8'h03, 8'h00, 8'h45, 8'h01, 8'hFF, 8'h0F, 8'h00, 8'hF8}, 0);
  endtask

  task automatic test_zero_len();
    do_reset();
    test_load("zero_len", '{8'h00, 8'h00}, 0);
  endtask

  task automatic test_toggle();
    do_reset();
    tog = 1'b0;
    test_load("toggle", '{8'h03, 8'h00, 8'h45, 8'h01, 8'hFF, 8'h0F, 8'h00, 8'hF8}, 1);
  endtask

  task automatic test_random();
    byte_q_t s;
    int len;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      len = $urandom_range(1, 6);
      s.delete();
      s.push_back(8'(len));
      s.push_back(8'($urandom_range(0, 15) << 4));
      for (int i = 0; i < 2 * len; i++) s.push_back(8'($urandom));
      test_load("random", s, 2);
    end
  endtask

  task automatic test_capacity();
    byte_q_t s;
    do_reset();
    s.delete();
    s.push_back(8'h00);
    s.push_back(8'h01);
    for (int i = 0; i < 2 * (1 << IMW); i++) s.push_back(8'($urandom));
    test_load("capacity", s, 0);
  endtask

  task automatic test_error();
    bit ok;
    do_reset();
    @(negedge clk);
    load_en = 1'b1;
    send_byte(8'h01, 0, ok);
    send_byte(8'h01, 0, ok);
    @(negedge clk);
    rx_valid = 1'b0;
    load_en  = 1'b0;
    repeat (8) begin
      #1;
      checks++;
      if ({error, rx_ready, cpu_reset, busy} !== 4'b1010) begin
        errors++;
        $display("FAIL error sticky: got error/rx_ready/cpu_reset/busy %b%b%b%b, required 1010",
                 error, rx_ready, cpu_reset, busy);
      end
      @(negedge clk);
    end
    checks++;
    if (start_cnt != 0 || wr_addr.size() != 0) begin
      errors++;
      $display("FAIL error activity: got %0d starts %0d writes, required 0 0", start_cnt,
               wr_addr.size());
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    byte_q_t pre;
    do_reset();
    pre = '{8'h03, 8'h00, 8'h45, 8'h01};
    @(negedge clk);
    load_en = 1'b1;
    foreach (pre[i]) send_byte(pre[i], 0, ok);
    do_reset();
    checks++;
    if (im_addr !== '0 || im_data !== '0 || cpu_reset !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midload reset: got addr %0h data %0h cpu_reset %b busy %b, required 0 0 1 0",
               im_addr, im_data, cpu_reset, busy);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (wr_addr.size() != 0) begin
      errors++;
      $display("FAIL midload stray writes: got %0d, required 0", wr_addr.size());
    end
    test_load("midload_reload", '{8'h01, 8'h00, 8'hAB, 8'hF2}, 0);
  endtask

  task automatic test_reload();
    byte_q_t s;
    do_reset();
    test_load("reload_first", '{8'h02, 8'h00, 8'h11, 8'h03, 8'h22, 8'h04}, 0);
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reload idle: got cpu_reset %b start %b busy %b, required 1 0 0",
               cpu_reset, start, busy);
    end
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload rearm: got cpu_reset %b rx_ready %b, required 1 1", cpu_reset,
               rx_ready);
    end
    s = '{8'h02, 8'h00};
    for (int i = 0; i < 4; i++) s.push_back(8'($urandom));
    test_load("reload_second", s, 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_error();
    test_toggle();
    test_random();
    test_capacity();
    test_reset_midload();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
